// File: rtl/pc_if.sv
// Interface carrying the fetch PC unit's control inputs from the decode/hazard
// logic and its PC outputs.
interface pc_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             stall;
    logic [2:0]       npc_op;
    logic [25:0]      imm26;
    logic [WIDTH-1:0] d_pc;
    logic             b_jump;
    logic [WIDTH-1:0] ra;
    logic             exc_req;
    logic             eret_req;
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] f_pc;
    logic [WIDTH-1:0] pc8;
    logic             redirect_pending;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output stall, npc_op, imm26, d_pc, b_jump, ra, exc_req, eret_req, epc,
        input  f_pc, pc8, redirect_pending, redirect_cnt
    );

    modport slave (
        input  stall, npc_op, imm26, d_pc, b_jump, ra, exc_req, eret_req, epc,
        output f_pc, pc8, redirect_pending, redirect_cnt
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch PC register with next-PC selection, a one-entry buffer that holds a
// redirect raised while fetch is stalled, and a saturating redirect counter.
module pc_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_PC   = 32'h0000_4180,
    parameter int               CNT_W    = 16
) (
    input logic clk,
    input logic reset,
    pc_if.slave bus
);
    localparam logic [2:0] OP_PC4   = 3'd0;
    localparam logic [2:0] OP_BRNCH = 3'd1;
    localparam logic [2:0] OP_J     = 3'd2;
    localparam logic [2:0] OP_JR    = 3'd3;

    logic [WIDTH-1:0] f_pc_q;
    logic [WIDTH-1:0] buf_tgt_q;
    logic             pending_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] j_tgt;
    logic [WIDTH-1:0] target;
    logic             is_redirect;
    logic [CNT_W-1:0] cnt_inc;

    assign pc4    = f_pc_q + WIDTH'(4);
    assign br_off = {{(WIDTH-18){bus.imm26[15]}}, bus.imm26[15:0], 2'b00};
    assign br_tgt = bus.d_pc + WIDTH'(4) + br_off;

    // Jump keeps the upper region bits of the D-stage PC when the PC is wider than 28 bits.
    generate
        if (WIDTH > 28) begin : g_j_region
            assign j_tgt = {bus.d_pc[WIDTH-1:28], bus.imm26, 2'b00};
        end else begin : g_j_flat
            assign j_tgt = {bus.imm26, 2'b00};
        end
    endgenerate

    always_comb begin
        target      = pc4;
        is_redirect = 1'b0;
        case (bus.npc_op)
            OP_BRNCH: begin
                if (bus.b_jump) begin
                    target      = br_tgt;
                    is_redirect = 1'b1;
                end
            end
            OP_J: begin
                target      = j_tgt;
                is_redirect = 1'b1;
            end
            OP_JR: begin
                target      = bus.ra;
                is_redirect = 1'b1;
            end
            default: begin
                target      = pc4;
                is_redirect = 1'b0;
            end
        endcase
    end

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_pc_q    <= RESET_PC;
            buf_tgt_q <= '0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else if (bus.exc_req) begin
            f_pc_q    <= EXC_PC;
            buf_tgt_q <= '0;
            pending_q <= 1'b0;
            cnt_q     <= cnt_inc;
        end else if (bus.eret_req) begin
            f_pc_q    <= bus.epc;
            buf_tgt_q <= '0;
            pending_q <= 1'b0;
            cnt_q     <= cnt_inc;
        end else if (bus.stall) begin
            // Only the first redirect seen during a stall is kept.
            if (is_redirect && !pending_q) begin
                buf_tgt_q <= target;
                pending_q <= 1'b1;
            end
        end else if (pending_q) begin
            f_pc_q    <= buf_tgt_q;
            buf_tgt_q <= '0;
            pending_q <= 1'b0;
            cnt_q     <= cnt_inc;
        end else begin
            f_pc_q <= target;
            if (is_redirect) begin
                cnt_q <= cnt_inc;
            end
        end
    end

    assign bus.f_pc             = f_pc_q;
    assign bus.pc8              = f_pc_q + WIDTH'(8);
    assign bus.redirect_pending = pending_q;
    assign bus.redirect_cnt     = cnt_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: expected PC/pending/count triples are queued when
// stimulus is applied and compared after the following clock edge.
module tb_pc_unit;
    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_fail;
    int   n_total;
    exp_t sb_q[$];

    pc_if #(.WIDTH(32), .CNT_W(16)) bus ();
    pc_if #(.WIDTH(32), .CNT_W(2))  bus2 ();

    pc_unit #(.WIDTH(32), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pc_unit #(.WIDTH(32), .CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input logic [31:0] pc, input logic pend, input logic [15:0] cnt);
        exp_t e;
        e.pc   = pc;
        e.pend = pend;
        e.cnt  = cnt;
        sb_q.push_back(e);
    endtask

    task automatic compare_now(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_f_pc"}, bus.f_pc, e.pc);
            check({tag, "_pc8"}, bus.pc8, e.pc + 32'd8);
            check({tag, "_pending"}, {31'd0, bus.redirect_pending}, {31'd0, e.pend});
            check({tag, "_cnt"}, {16'd0, bus.redirect_cnt}, {16'd0, e.cnt});
        end
    endtask

    task automatic step(input string tag, input logic [31:0] pc, input logic pend,
                        input logic [15:0] cnt);
        expect_state(pc, pend, cnt);
        @(posedge clk);
        #1;
        compare_now(tag);
    endtask

    initial begin
        logic [1:0] sat_exp [4];
        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        sat_exp[0] = 2'd1;
        sat_exp[1] = 2'd2;
        sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3;

        reset        = 1'b0;
        bus.stall    = 1'b0;
        bus.npc_op   = 3'd0;
        bus.imm26    = 26'd0;
        bus.d_pc     = 32'd0;
        bus.b_jump   = 1'b0;
        bus.ra       = 32'd0;
        bus.exc_req  = 1'b0;
        bus.eret_req = 1'b0;
        bus.epc      = 32'd0;
        bus2.stall    = 1'b0;
        bus2.npc_op   = 3'd0;
        bus2.imm26    = 26'd0;
        bus2.d_pc     = 32'd0;
        bus2.b_jump   = 1'b0;
        bus2.ra       = 32'd0;
        bus2.exc_req  = 1'b0;
        bus2.eret_req = 1'b0;
        bus2.epc      = 32'd0;

        #12;
        expect_state(32'h3000, 1'b0, 16'd0);
        compare_now("reset");

        @(negedge clk);
        reset = 1'b1;
        step("seq1", 32'h3004, 1'b0, 16'd0);
        step("seq2", 32'h3008, 1'b0, 16'd0);
        step("seq3", 32'h300C, 1'b0, 16'd0);

        // Taken branch backwards: 0x3010 + 4 - 8.
        bus.d_pc   = 32'h3010;
        bus.npc_op = 3'd1;
        bus.b_jump = 1'b1;
        bus.imm26  = 26'h000FFFE;
        step("br_taken", 32'h300C, 1'b0, 16'd1);
        bus.npc_op = 3'd0;
        step("walk1", 32'h3010, 1'b0, 16'd1);
        step("walk2", 32'h3014, 1'b0, 16'd1);
        bus.npc_op = 3'd1;
        bus.b_jump = 1'b0;
        step("br_not_taken", 32'h3018, 1'b0, 16'd1);

        // Jump while stalled is buffered; a later JR during the same stall loses.
        bus.stall  = 1'b1;
        bus.npc_op = 3'd2;
        bus.imm26  = 26'h0000C40;
        bus.d_pc   = 32'h3000;
        step("stall_j", 32'h3018, 1'b1, 16'd1);
        bus.npc_op = 3'd3;
        bus.ra     = 32'h5000;
        step("stall_jr_ignored", 32'h3018, 1'b1, 16'd1);
        bus.stall = 1'b0;
        step("apply_buffer", 32'h3100, 1'b0, 16'd2);

        bus.stall  = 1'b1;
        bus.npc_op = 3'd2;
        step("stall_j2", 32'h3100, 1'b1, 16'd2);
        bus.exc_req = 1'b1;
        step("exc_over_stall", 32'h4180, 1'b0, 16'd3);
        bus.exc_req  = 1'b0;
        bus.eret_req = 1'b1;
        bus.epc      = 32'h3204;
        step("eret", 32'h3204, 1'b0, 16'd4);
        bus.eret_req = 1'b0;
        bus.stall    = 1'b0;
        bus.npc_op   = 3'd0;
        step("after_eret", 32'h3208, 1'b0, 16'd4);

        bus.npc_op = 3'd3;
        bus.ra     = 32'h5002;
        step("jr_unaligned", 32'h5002, 1'b0, 16'd5);
        bus.npc_op = 3'd5;
        step("op_other_pc4", 32'h5006, 1'b0, 16'd5);
        bus.exc_req  = 1'b1;
        bus.eret_req = 1'b1;
        step("exc_over_eret", 32'h4180, 1'b0, 16'd6);
        bus.exc_req  = 1'b0;
        bus.eret_req = 1'b0;

        bus.npc_op = 3'd3;
        bus.ra     = 32'h3400;
        step("jr_3400", 32'h3400, 1'b0, 16'd7);
        bus.stall  = 1'b1;
        bus.npc_op = 3'd2;
        step("pend_3400", 32'h3400, 1'b1, 16'd7);

        // Asynchronous reset between edges drops the buffered jump.
        #2;
        reset = 1'b0;
        #1;
        expect_state(32'h3000, 1'b0, 16'd0);
        compare_now("async_reset");
        @(negedge clk);
        bus.stall  = 1'b0;
        bus.npc_op = 3'd0;
        reset      = 1'b1;
        step("post_reset", 32'h3004, 1'b0, 16'd0);

        bus2.npc_op = 3'd2;
        bus2.imm26  = 26'h0000C40;
        bus2.d_pc   = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat_cnt%0d", i), {30'd0, bus2.redirect_cnt}, {30'd0, sat_exp[i]});
        end
        check("sat_f_pc", bus2.f_pc, 32'h3100);

        if (sb_q.size() != 0) check("sb_leftover", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, PC/address width (min 28).
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_3000, PC value after reset.
REQ-003 SHALL provide parameter EXC_PC, default 32'h0000_4180, exception handler entry.
REQ-004 SHALL provide parameter CNT_W, default 16, redirect counter width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 stall  in  1  fetch freeze request from hazard unit.
REQ-008 npc_op  in  3  0=PC4, 1=BRNCH, 2=J, 3=JR, others=PC4.
REQ-009 imm26  in  26  D-stage immediate; imm26[15:0] is branch offset.
REQ-010 d_pc  in  WIDTH  PC of instruction in D stage.
REQ-011 b_jump  in  1  branch-taken flag from D-stage comparator.
REQ-012 ra  in  WIDTH  forwarded register value for JR.
REQ-013 exc_req  in  1  exception redirect request.
REQ-014 eret_req  in  1  return-from-exception request.
REQ-015 epc  in  WIDTH  exception return address.
REQ-016 f_pc  out  WIDTH  registered fetch PC.
REQ-017 pc8  out  WIDTH  f_pc+8, combinational link value.
REQ-018 redirect_pending  out  1  registered; a deferred redirect is buffered.
REQ-019 redirect_cnt  out  CNT_W  registered count of applied redirects.

Function
REQ-020 Target SHALL be: PC4 -> f_pc+4; BRNCH with b_jump=1 -> d_pc+4+(sign-extended imm26[15:0]<<2); BRNCH with b_jump=0 -> f_pc+4; J -> {d_pc[WIDTH-1:28], imm26, 2'b00}; JR -> ra.
REQ-021 A "redirect" SHALL be BRNCH taken, J, or JR; all arithmetic modulo 2^WIDTH, no overflow flag.
REQ-022 Next-PC priority SHALL be exc_req > eret_req > buffered redirect > npc_op target.
REQ-023 exc_req=1 SHALL load f_pc<=EXC_PC next edge regardless of stall, and clear the buffer.
REQ-024 eret_req=1 (exc_req=0) SHALL load f_pc<=epc next edge regardless of stall, and clear the buffer.
REQ-025 stall=1, no exc/eret: f_pc SHALL hold; a redirect with empty buffer SHALL latch its target and set redirect_pending=1.
REQ-026 stall=1 with buffer full: further redirects SHALL be ignored (first wins); buffer holds.
REQ-027 stall=0 with buffer full: f_pc SHALL load buffered target, buffer clears, npc_op ignored that cycle.
REQ-028 stall=0, buffer empty: f_pc SHALL load REQ-020 target.
REQ-029 redirect_cnt SHALL increment by 1 on each edge where f_pc loads a redirect, buffered target, EXC_PC or epc; latching into buffer alone does not count.
REQ-030 redirect_cnt SHALL saturate at all-ones, never wrap.
REQ-031 pc8 SHALL equal f_pc+8 in the same cycle (zero latency).
REQ-032 JR target with nonzero low 2 bits SHALL be loaded unmodified (alignment checked downstream).

Reset
REQ-033 reset=0 SHALL immediately force f_pc=RESET_PC, redirect_pending=0, buffer target=0, redirect_cnt=0, independent of clk.
REQ-034 Reset asserted mid-stall with buffer full SHALL discard the buffered redirect.
REQ-035 First edge after reset release SHALL apply normal REQ-022 priority.

Verification
REQ-036 Release reset, npc_op=PC4, stall=0, 3 edges -> f_pc 0x3000,0x3004,0x3008,0x300C; pc8=0x3014 at end; redirect_cnt=0.
REQ-037 d_pc=0x3010, npc_op=BRNCH, b_jump=1, imm26[15:0]=0xFFFE -> f_pc=0x300C next edge, redirect_cnt=1; same with b_jump=0 and f_pc=0x3014 -> 0x3018, count unchanged.
REQ-038 stall=1, npc_op=J, imm26=0x0000C40, d_pc=0x3000 -> f_pc holds, redirect_pending=1; next cycle JR ra=0x5000 still stalled -> ignored; stall=0 -> f_pc=0x3100, pending=0.
REQ-039 stall=1 with pending set, exc_req=1 -> f_pc=0x4180 next edge, pending=0; then eret_req=1, epc=0x3204 -> f_pc=0x3204.
REQ-040 CNT_W=2, four consecutive J redirects -> redirect_cnt 1,2,3,3 (saturated).
REQ-041 Assert reset between edges with pending=1, f_pc=0x3400 -> f_pc=0x3000, pending=0, cnt=0 before next clk edge.
